demux2_reg: RTL

- Registered 1-to-2 stream demultiplexer, the inverse of the 2:1 datapath mux.
- Routes one input word per handshake to output A (sel_i=1) or output B (sel_i=0), matching the mux select polarity (sel=1 -> a, sel=0 -> b).
- Each output has a one-entry output register with valid/ready handshake, plus a wrapping per-output delivery counter.
- Sits between a PE-array result path and two downstream consumers (e.g. psum accumulate vs. write-back).

---
 rtl/demux2_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/demux2_reg.sv
// Registered 1-to-2 stream demultiplexer.
// One input word per handshake is steered to output A (sel_i=1) or output B (sel_i=0).
// Each output has a one-entry register with a valid/ready handshake.
// Each output also has a wrapping counter of completed deliveries.
module demux2_reg #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  sel_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] a_o,
   output logic                  a_valid_o,
   input  logic                  a_ready_i,
   output logic [DATA_WIDTH-1:0] b_o,
   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   output logic [CNT_WIDTH-1:0]  a_cnt_o,
   output logic [CNT_WIDTH-1:0]  b_cnt_o
);

   // Occupancy of one output register
   typedef enum logic [0:0] {
      StEmpty,
      StFull
   } side_state_e;

   side_state_e a_state_q, a_state_d;
   side_state_e b_state_q, b_state_d;

   logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
   logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
   logic [CNT_WIDTH-1:0]  a_cnt_q, a_cnt_d;
   logic [CNT_WIDTH-1:0]  b_cnt_q, b_cnt_d;

   logic a_full, b_full;
   logic a_free, b_free;
   logic accept;
   logic a_load, b_load;
   logic a_drain, b_drain;

   // Handshake decode: a side can take a word if it is empty or is emptying this cycle
   always_comb begin
      a_full  = (a_state_q == StFull);
      b_full  = (b_state_q == StFull);
      a_free  = !a_full || a_ready_i;
      b_free  = !b_full || b_ready_i;
      // ready_o must not depend on valid_i
      ready_o = sel_i ? a_free : b_free;
      accept  = valid_i && ready_o;
      a_load  = accept && sel_i;
      b_load  = accept && !sel_i;
      a_drain = a_full && a_ready_i;
      b_drain = b_full && b_ready_i;
   end

   // State registers; reset drops buffered words without counting them
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_state_q <= StEmpty;
         b_state_q <= StEmpty;
         a_data_q  <= '0;
         b_data_q  <= '0;
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
      end else begin
         a_state_q <= a_state_d;
         b_state_q <= b_state_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
         a_cnt_q   <= a_cnt_d;
         b_cnt_q   <= b_cnt_d;
      end
   end

   // Next-state for side A: a load wins over a drain so back-to-back words see no bubble
   always_comb begin
      a_state_d = a_state_q;
      unique case (a_state_q)
         StEmpty: begin
            if (a_load) a_state_d = StFull;
         end
         StFull: begin
            if (a_drain && !a_load) a_state_d = StEmpty;
         end
         default: a_state_d = StEmpty;
      endcase
   end

   // Next-state for side B, same rules as A
   always_comb begin
      b_state_d = b_state_q;
      unique case (b_state_q)
         StEmpty: begin
            if (b_load) b_state_d = StFull;
         end
         StFull: begin
            if (b_drain && !b_load) b_state_d = StEmpty;
         end
         default: b_state_d = StEmpty;
      endcase
   end

   // Datapath and counters: data holds its last value after a drain, counters wrap silently
   always_comb begin
      a_data_d = a_load ? data_i : a_data_q;
      b_data_d = b_load ? data_i : b_data_q;
      a_cnt_d  = a_drain ? a_cnt_q + CNT_WIDTH'(1) : a_cnt_q;
      b_cnt_d  = b_drain ? b_cnt_q + CNT_WIDTH'(1) : b_cnt_q;
   end

   // Outputs come straight from registers, never from data_i
   always_comb begin
      a_valid_o = (a_state_q == StFull);
      b_valid_o = (b_state_q == StFull);
      a_o       = a_data_q;
      b_o       = b_data_q;
      a_cnt_o   = a_cnt_q;
      b_cnt_o   = b_cnt_q;
   end

endmodule
